// File: rtl/measure_display_if.sv
// Measurement result interface: the measurement block (master) writes num/load,
// the display block (slave) returns status, BCD digits and segment codes.
interface measure_display_if #(
   parameter int WIDTH = 14
);
   logic [WIDTH-1:0] num;
   logic             load;
   logic             busy;
   logic             done;
   logic [15:0]      bcd;
   logic [6:0]       HEX0;
   logic [6:0]       HEX1;
   logic [6:0]       HEX2;
   logic [6:0]       HEX3;

   modport master (
      output num, load,
      input  busy, done, bcd, HEX0, HEX1, HEX2, HEX3
   );

   modport slave (
      input  num, load,
      output busy, done, bcd, HEX0, HEX1, HEX2, HEX3
   );
endinterface

// File: rtl/measure_display.sv
// Sequential shift-add-3 binary-to-BCD converter driving four active-low 7-seg digits.
// Optional leading-zero blanking is enabled by defining MEASURE_DISPLAY_BLANK_EN.
module measure_display #(
   parameter int WIDTH = 14
) (
   input logic              clock,
   input logic              resetn,
   measure_display_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      UPDATE = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   state_t           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [15:0]      acc_q;
   logic [3:0]       cnt_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;
   logic [15:0]      bcd_q;
   logic [6:0]       hex0_q, hex1_q, hex2_q, hex3_q;

   logic [15:0]      acc_adj_s;
   logic [15:0]      acc_d;
   logic [WIDTH-1:0] shreg_d;
   logic [15:0]      bcd_d;
   logic [6:0]       hex0_d, hex1_d, hex2_d, hex3_d;
   logic             blank1_s, blank2_s, blank3_s;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Next shift step, captured digit image and segment encoding
   always_comb begin
      acc_adj_s = {add3(acc_q[15:12]), add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};
      acc_d     = {acc_adj_s[14:0], shreg_q[WIDTH-1]};
      shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
      bcd_d     = ovf_q ? 16'h9999 : acc_q;
`ifdef MEASURE_DISPLAY_BLANK_EN
      blank3_s  = (acc_q[15:12] == 4'd0);
      blank2_s  = blank3_s && (acc_q[11:8] == 4'd0);
      blank1_s  = blank2_s && (acc_q[7:4] == 4'd0);
`else
      blank3_s  = 1'b0;
      blank2_s  = 1'b0;
      blank1_s  = 1'b0;
`endif
      // Dashes take priority so an overflow is never blanked
      hex3_d = ovf_q ? SEG_DASH : (blank3_s ? SEG_BLANK : seg7(acc_q[15:12]));
      hex2_d = ovf_q ? SEG_DASH : (blank2_s ? SEG_BLANK : seg7(acc_q[11:8]));
      hex1_d = ovf_q ? SEG_DASH : (blank1_s ? SEG_BLANK : seg7(acc_q[7:4]));
      hex0_d = ovf_q ? SEG_DASH : seg7(acc_q[3:0]);
   end

   // Control FSM with registered datapath and outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         shreg_q <= '0;
         acc_q   <= 16'h0000;
         cnt_q   <= 4'd0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= 16'h0000;
         hex0_q  <= SEG_BLANK;
         hex1_q  <= SEG_BLANK;
         hex2_q  <= SEG_BLANK;
         hex3_q  <= SEG_BLANK;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.load) begin
                  shreg_q <= bus.num;
                  acc_q   <= 16'h0000;
                  cnt_q   <= 4'd0;
                  ovf_q   <= (bus.num > WIDTH'(9999));
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end else begin
                  state_q <= IDLE;
               end
            end
            SHIFT: begin
               acc_q   <= acc_d;
               shreg_q <= shreg_d;
               cnt_q   <= cnt_q + 4'd1;
               if (cnt_q == 4'(WIDTH - 1)) begin
                  state_q <= UPDATE;
               end else begin
                  state_q <= SHIFT;
               end
            end
            UPDATE: begin
               bcd_q   <= bcd_d;
               hex0_q  <= hex0_d;
               hex1_q  <= hex1_d;
               hex2_q  <= hex2_d;
               hex3_q  <= hex3_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.bcd  = bcd_q;
   assign bus.HEX0 = hex0_q;
   assign bus.HEX1 = hex1_q;
   assign bus.HEX2 = hex2_q;
   assign bus.HEX3 = hex3_q;

endmodule

// File: tb/tb_measure_display.sv
// Table-driven bench for measure_display plus hand-written sequences for
// ignored load, back-to-back conversions and reset mid-conversion.
module tb_measure_display;

   logic clock;
   logic resetn;
   int   checks;
   int   failures;

`ifdef MEASURE_DISPLAY_BLANK_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'h40;
`endif

   typedef struct {
      logic [13:0] num;
      logic [15:0] bcd;
      logic [6:0]  h3, h2, h1, h0;
   } vec_t;

   vec_t vecs[9];

   measure_display_if #(.WIDTH(14)) bus ();

   measure_display #(.WIDTH(14)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_bcd"},  32'(bus.bcd),  32'h0000);
      chk({tag, "_hex"},  {4'd0, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
   endtask

   task automatic chk_display(input string tag, input logic [15:0] b,
                              input logic [6:0] h3, input logic [6:0] h2,
                              input logic [6:0] h1, input logic [6:0] h0);
      chk({tag, "_bcd"},  32'(bus.bcd), 32'(b));
      chk({tag, "_hex3"}, 32'(bus.HEX3), 32'(h3));
      chk({tag, "_hex2"}, 32'(bus.HEX2), 32'(h2));
      chk({tag, "_hex1"}, 32'(bus.HEX1), 32'(h1));
      chk({tag, "_hex0"}, 32'(bus.HEX0), 32'(h0));
   endtask

   // One conversion: load n, expect done 15 edges later, busy low with it, done for one cycle
   task automatic run_conv(input string tag, input logic [13:0] n);
      int lat;
      @(negedge clock);
      bus.num  = n;
      bus.load = 1'b1;
      @(posedge clock); #1;
      chk({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
      @(negedge clock);
      bus.load = 1'b0;
      bus.num  = ~n;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock); #1;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_latency"}, 32'(lat), 32'd15);
      chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
      @(posedge clock); #1;
      chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int ndone;
      int first_done;
      int second_done;

      checks   = 0;
      failures = 0;

      vecs[0] = '{14'd1234,  16'h1234, 7'h79, 7'h24, 7'h30, 7'h19};
      vecs[1] = '{14'd7,     16'h0007, LZ,    LZ,    LZ,    7'h78};
      vecs[2] = '{14'd0,     16'h0000, LZ,    LZ,    LZ,    7'h40};
      vecs[3] = '{14'd10000, 16'h9999, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
      vecs[4] = '{14'd16383, 16'h9999, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
      vecs[5] = '{14'd9999,  16'h9999, 7'h10, 7'h10, 7'h10, 7'h10};
      vecs[6] = '{14'd56,    16'h0056, LZ,    LZ,    7'h12, 7'h02};
      vecs[7] = '{14'd805,   16'h0805, LZ,    7'h00, 7'h40, 7'h12};
      vecs[8] = '{14'd4321,  16'h4321, 7'h19, 7'h30, 7'h24, 7'h79};

      resetn   = 1'b0;
      bus.num  = 14'd0;
      bus.load = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk_reset_state("reset");
      @(negedge clock);
      resetn = 1'b1;

      for (int v = 0; v < 9; v++) begin
         run_conv($sformatf("vec%0d", v), vecs[v].num);
         chk_display($sformatf("vec%0d", v), vecs[v].bcd, vecs[v].h3, vecs[v].h2, vecs[v].h1, vecs[v].h0);
      end

      // load during busy is ignored: 9999 then a pulse of 1111 at the 5th busy cycle
      @(negedge clock);
      bus.num  = 14'd9999;
      bus.load = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.load = 1'b0;
      ndone = 0;
      first_done = -1;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clock); #1;
         if (bus.done) begin
            ndone++;
            if (first_done < 0) first_done = i;
         end
         if (i == 15) chk("ign_busy_drop", 32'(bus.busy), 32'd0);
         @(negedge clock);
         bus.load = (i == 4);
         bus.num  = (i == 4) ? 14'd1111 : 14'd9999;
      end
      bus.load = 1'b0;
      chk("ign_done_count", 32'(ndone), 32'd1);
      chk("ign_done_lat", 32'(first_done), 32'd15);
      chk_display("ign", 16'h9999, 7'h10, 7'h10, 7'h10, 7'h10);

      // load held high: captures at k and k+16, num switches to 56 mid-first conversion
      @(negedge clock);
      bus.num  = 14'd1234;
      bus.load = 1'b1;
      @(posedge clock);
      first_done  = -1;
      second_done = -1;
      for (int i = 1; i <= 40; i++) begin
         if (i == 3) begin
            @(negedge clock);
            bus.num = 14'd56;
         end
         @(posedge clock); #1;
         if (bus.done) begin
            if (first_done < 0) begin
               first_done = i;
               chk_display("b2b_first", 16'h1234, 7'h79, 7'h24, 7'h30, 7'h19);
            end else begin
               second_done = i;
               break;
            end
         end
      end
      @(negedge clock);
      bus.load = 1'b0;
      chk("b2b_first_lat", 32'(first_done), 32'd15);
      chk("b2b_second_lat", 32'(second_done), 32'd31);
      chk_display("b2b_second", 16'h0056, LZ, LZ, 7'h12, 7'h02);
      repeat (20) @(posedge clock);

      // reset asserted at the 7th shift of a 4321 conversion
      @(negedge clock);
      bus.num  = 14'd4321;
      bus.load = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.load = 1'b0;
      repeat (7) @(posedge clock);
      #2;
      resetn = 1'b0;
      #1;
      chk_reset_state("midrst");
      ndone = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clock); #1;
         if (bus.done) ndone++;
         if (i == 2) resetn = 1'b1;
      end
      chk("midrst_no_done", 32'(ndone), 32'd0);
      chk("midrst_idle_busy", 32'(bus.busy), 32'd0);
      run_conv("after_rst", 14'd4321);
      chk_display("after_rst", 16'h4321, 7'h19, 7'h30, 7'h24, 7'h79);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
